// File: rtl/count_seq_monitor.sv
// Sequence monitor for a 2-bit up-counter: checks +1/hold behaviour each edge,
// reports 3->0 wraps, a divided wrap pulse, and counts sequence-error episodes.
module count_seq_monitor #(
    parameter int WRAP_W      = 4,
    parameter int WRAP_THRESH = 10,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cnt_in,
    input  logic              cnt_en,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              div_pulse,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ERROR = 2'b10
    } state_t;

    localparam logic [WRAP_W-1:0] THRESH_M1 = WRAP_W'(WRAP_THRESH - 1);

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] prev;
    logic       en_q;

    logic [1:0] exp_cnt;
    logic       mismatch;
    logic       err_evt;
    logic       wrap_evt;
    logic       thresh_hit;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; clr overrides any same-edge mismatch.
    // NOTE: default assignment first so no path leaves nxt_state unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        nxt_state = cur_state;
        if (clr) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:    nxt_state = TRACK;
                TRACK:   nxt_state = mismatch ? ERROR : TRACK;
                ERROR:   nxt_state = ERROR;
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Event decode: what the registered outputs should report after this edge.
    always_comb begin
        exp_cnt    = en_q ? prev + 2'd1 : prev;
        mismatch   = (cnt_in != exp_cnt);
        err_evt    = !clr && (cur_state == TRACK) && mismatch;
        wrap_evt   = !clr && (cur_state == TRACK) && !mismatch
                     && en_q && (prev == 2'd3) && (cnt_in == 2'd0);
        thresh_hit = (wrap_cnt == THRESH_M1);
    end

    // Sample history and registered outputs; err_cnt survives clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= 2'd0;
            en_q       <= 1'b0;
            wrap_pulse <= 1'b0;
            div_pulse  <= 1'b0;
            wrap_cnt   <= '0;
            seq_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            prev       <= cnt_in;
            en_q       <= cnt_en;
            wrap_pulse <= wrap_evt;
            div_pulse  <= wrap_evt && thresh_hit;
            if (clr) begin
                seq_err  <= 1'b0;
                wrap_cnt <= '0;
            end else begin
                if (err_evt) begin
                    seq_err <= 1'b1;
                    if (err_cnt != {ERR_W{1'b1}}) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                end
                if (wrap_evt) begin
                    wrap_cnt <= thresh_hit ? '0 : wrap_cnt + WRAP_W'(1);
                end
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Randomized bench for count_seq_monitor: two instances (default and
// WRAP_THRESH=1/ERR_W=2) compared every cycle against a rule-level model.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cnt_in = 2'd0;
    logic       cnt_en = 1'b0;
    logic       clr = 1'b0;

    logic       wp0, dp0, se0, wp1, dp1, se1;
    logic [3:0] wc0, wc1;
    logic [7:0] ec0;
    logic [1:0] ec1;
    logic [1:0] st0, st1;

    int n_total = 0;
    int n_bad   = 0;
    int ctr     = 0;

    // Reference model: phase 0=idle, 1=tracking, 2=errored.
    int m_phase[2], m_prev[2], m_en[2], m_wraps[2], m_err[2], m_seq[2], m_wp[2], m_dp[2];
    int thresh[2] = '{10, 1};
    int errmax[2] = '{255, 3};

    always #5 clk = ~clk;

    count_seq_monitor #(.WRAP_W(4), .WRAP_THRESH(10), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_en(cnt_en), .clr(clr),
        .wrap_pulse(wp0), .wrap_cnt(wc0), .div_pulse(dp0),
        .seq_err(se0), .err_cnt(ec0), .state(st0)
    );

    count_seq_monitor #(.WRAP_W(4), .WRAP_THRESH(1), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_en(cnt_en), .clr(clr),
        .wrap_pulse(wp1), .wrap_cnt(wc1), .div_pulse(dp1),
        .seq_err(se1), .err_cnt(ec1), .state(st1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_prev[i] = 0; m_en[i] = 0; m_wraps[i] = 0;
            m_err[i] = 0; m_seq[i] = 0; m_wp[i] = 0; m_dp[i] = 0;
        end
    endtask

    task automatic model_step(input int c, input int e, input int cl);
        for (int i = 0; i < 2; i++) begin
            m_wp[i] = 0;
            m_dp[i] = 0;
            if (cl != 0) begin
                m_phase[i] = 0;
                m_seq[i]   = 0;
                m_wraps[i] = 0;
            end else if (m_phase[i] == 0) begin
                m_phase[i] = 1;
            end else if (m_phase[i] == 1) begin
                if (c != (m_prev[i] + m_en[i]) % 4) begin
                    m_phase[i] = 2;
                    m_seq[i]   = 1;
                    if (m_err[i] < errmax[i]) m_err[i]++;
                end else if (m_en[i] == 1 && m_prev[i] == 3 && c == 0) begin
                    m_wp[i] = 1;
                    m_wraps[i]++;
                    if (m_wraps[i] == thresh[i]) begin
                        m_wraps[i] = 0;
                        m_dp[i]    = 1;
                    end
                end
            end
            m_prev[i] = c;
            m_en[i]   = e;
        end
    endtask

    task automatic compare_all();
        check("wrap_pulse0", 32'(wp0), 32'(m_wp[0]));
        check("div_pulse0",  32'(dp0), 32'(m_dp[0]));
        check("wrap_cnt0",   32'(wc0), 32'(m_wraps[0]));
        check("seq_err0",    32'(se0), 32'(m_seq[0]));
        check("err_cnt0",    32'(ec0), 32'(m_err[0]));
        check("state0",      32'(st0), 32'(m_phase[0]));
        check("wrap_pulse1", 32'(wp1), 32'(m_wp[1]));
        check("div_pulse1",  32'(dp1), 32'(m_dp[1]));
        check("wrap_cnt1",   32'(wc1), 32'(m_wraps[1]));
        check("seq_err1",    32'(se1), 32'(m_seq[1]));
        check("err_cnt1",    32'(ec1), 32'(m_err[1]));
        check("state1",      32'(st1), 32'(m_phase[1]));
    endtask

    // Drive inputs, take one edge, update the model, sample 1 ns later.
    task automatic step(input int c, input int e, input int cl);
        cnt_in = 2'(c);
        cnt_en = 1'(e);
        clr    = 1'(cl);
        @(posedge clk);
        model_step(c, e, cl);
        #1;
        compare_all();
        clr = 1'b0;
        ctr = (c + e) % 4;
    endtask

    // Async reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int div_seen;
    int saved_wc;
    int saved_err;
    int budget;
    int r;
    int bad_v;

    initial begin
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        ctr = 0;

        // Free-running counter: 10 wraps in 44 edges gives exactly one div_pulse.
        div_seen = 0;
        for (int i = 0; i < 44; i++) begin
            step(ctr, 1, 0);
            if (dp0) div_seen++;
        end
        check("div_after_10_wraps", 32'(div_seen), 32'd1);
        check("wrap_cnt_after_div", 32'(wc0), 32'd0);

        // Mid-count async reset once wrap_cnt reaches 5.
        budget = 0;
        while (m_wraps[0] != 5 && budget < 100) begin
            step(ctr, 1, 0);
            budget++;
        end
        check("reach_wrap5", 32'(wc0), 32'd5);
        do_reset();
        check("rst_state", 32'(st0), 32'd0);

        // Idle counter parked at 3 is legal and produces no wraps.
        budget = 0;
        while (ctr != 3 && budget < 8) begin
            step(ctr, 1, 0);
            budget++;
        end
        while (m_wraps[0] == 0 && budget < 40) begin
            step(ctr, 1, 0);
            budget++;
        end
        while (ctr != 3 && budget < 48) begin
            step(ctr, 1, 0);
            budget++;
        end
        saved_wc = int'(wc0);
        for (int i = 0; i < 20; i++) begin
            step(3, 0, 0);
            check("hold3_no_wrap", 32'(wp0), 32'd0);
        end
        check("hold3_seq_err", 32'(se0), 32'd0);
        check("hold3_wrap_cnt", 32'(wc0), 32'(saved_wc));

        // Illegal jump 1->3 while enabled.
        budget = 0;
        while (ctr != 1 && budget < 8) begin
            step(ctr, 1, 0);
            budget++;
        end
        step(1, 1, 0);
        step(3, 1, 0);
        check("jump_state", 32'(st0), 32'h2);
        check("jump_seq_err", 32'(se0), 32'd1);
        check("jump_err_cnt", 32'(ec0), 32'd1);
        step(0, 1, 0);
        check("err_no_wrap", 32'(wp0), 32'd0);
        step(ctr, 1, 1);
        check("clr_state_idle", 32'(st0), 32'd0);
        check("clr_seq_err", 32'(se0), 32'd0);
        step(ctr, 1, 0);
        check("clr_state_track", 32'(st0), 32'd1);

        // clr on the same edge as an illegal 2->0 jump.
        budget = 0;
        while (ctr != 2 && budget < 8) begin
            step(ctr, 1, 0);
            budget++;
        end
        saved_err = int'(ec0);
        step(2, 1, 0);
        step(0, 1, 1);
        check("clr_win_state", 32'(st0), 32'd0);
        check("clr_win_seq_err", 32'(se0), 32'd0);
        check("clr_win_err_cnt", 32'(ec0), 32'(saved_err));

        // Five error episodes: 2-bit counter saturates at 3.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(ctr, 1, 0);
            step(ctr, 1, 0);
            step(ctr, 1, 0);
            step((ctr + 2) % 4, 1, 0);
            check("sat_err_cnt1", 32'(ec1), 32'(k < 3 ? k : 3));
            check("sat_err_cnt0", 32'(ec0), 32'(k));
            step(ctr, 1, 1);
        end

        // Randomized traffic: mostly legal counting, some glitches and clears.
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                step(ctr, int'($urandom_range(0, 1)), 1);
            end else if (r < 7) begin
                bad_v = (ctr + int'($urandom_range(1, 3))) % 4;
                step(bad_v, int'($urandom_range(0, 1)), 0);
            end else begin
                step(ctr, (r < 80) ? 1 : 0, 0);
            end
            if (i == 700) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
